// File: rtl/vh_sweep_pkg.sv
// Shared types and helpers for the sweep checker.
//   state_t   : sweep FSM states
//   MISR_*    : signature polynomial and seed
//   misr_step : one MISR fold of a zero-extended response word
package vh_sweep_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

  function automatic logic [31:0] misr_step(input logic [31:0] sig, input logic [31:0] y);
    return {sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0) ^ y;
  endfunction

endpackage

// File: rtl/vh_sweep_checker_if.sv
// Stimulus/response bus between the checker and the DUT + golden pair.
//   a_out, b_out : stimulus vector (b_out is 1 bit wide and 0 when B_W=0)
//   y_dut, y_ref : responses from DUT and golden model
//   master : checker side, slave : DUT/golden side
interface vh_sweep_checker_if #(
  parameter int A_W = 4,
  parameter int B_W = 4,
  parameter int Y_W = 16
);
  localparam int BW1 = (B_W > 0) ? B_W : 1;

  logic [A_W-1:0] a_out;
  logic [BW1-1:0] b_out;
  logic [Y_W-1:0] y_dut;
  logic [Y_W-1:0] y_ref;

  modport master (output a_out, b_out, input y_dut, y_ref);
  modport slave  (input a_out, b_out, output y_dut, y_ref);
endinterface

// File: rtl/vh_tag_delay.sv
// LAT-deep delay line of {valid, idx} tags; it marks the cycle on which the
// response to an issued vector is present. LAT=0 is a plain wire.
//   clk, rst        : clock, synchronous active-high reset (clears the line)
//   in_vld, in_tag  : vector issued this cycle
//   out_vld, out_tag: vector whose response is present this cycle
module vh_tag_delay #(
  parameter int LAT = 0,
  parameter int TW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [TW-1:0] in_tag,
  output logic          out_vld,
  output logic [TW-1:0] out_tag
);

  if (LAT == 0) begin : g_wire
    logic unused_clk;
    assign unused_clk = clk ^ rst;
    assign out_vld    = in_vld;
    assign out_tag    = in_tag;
  end else begin : g_pipe
    logic [LAT-1:0]         vld_pipe;
    logic [LAT-1:0][TW-1:0] tag_pipe;

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_pipe <= '0;
        tag_pipe <= '0;
      end else begin
        vld_pipe[0] <= in_vld;
        tag_pipe[0] <= in_tag;
        for (int i = 1; i < LAT; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
          tag_pipe[i] <= tag_pipe[i-1];
        end
      end
    end

    assign out_vld = vld_pipe[LAT-1];
    assign out_tag = tag_pipe[LAT-1];
  end

endmodule

// File: rtl/vh_sweep_checker.sv
// Exhaustive-sweep harness: drives every {a,b} vector, compares DUT against
// golden LAT cycles later, counts mismatches (saturating), captures the first
// failing vector and folds y_dut into a 32-bit MISR.
//   clk, rst     : clock, synchronous active-high reset
//   start        : begin a sweep (honoured in IDLE/DONE only)
//   bus          : stimulus out / responses in
//   busy, done   : RUN|DRAIN, DONE (level)
//   pass         : done with zero mismatches
//   mismatch_cnt : saturating mismatch count
//   first_a/b    : first mismatching vector
//   signature    : MISR over sampled y_dut
module vh_sweep_checker
  import vh_sweep_pkg::*;
#(
  parameter int A_W = 4,
  parameter int B_W = 4,
  parameter int Y_W = 16,
  parameter int LAT = 0,
  localparam int BW1 = (B_W > 0) ? B_W : 1,
  localparam int N   = A_W + B_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  vh_sweep_checker_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         mismatch_cnt,
  output logic [A_W-1:0]      first_a,
  output logic [BW1-1:0]      first_b,
  output logic [31:0]         signature
);

  localparam logic [N-1:0] IDX_LAST   = '1;
  localparam logic [2:0]   DRAIN_LAST = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  state_t         state, state_nxt;
  logic [N-1:0]   idx;
  logic [2:0]     drain_cnt;
  logic           first_seen;
  logic           tag_vld;
  logic [N-1:0]   tag;
  logic [BW1-1:0] tag_b;
  logic [31:0]    y32;
  logic           go;

  // Stimulus is a pure function of idx, so it holds through DRAIN/DONE.
  assign bus.a_out = idx[N-1:B_W];
  if (B_W > 0) begin : g_b
    assign bus.b_out = idx[B_W-1:0];
    assign tag_b     = tag[B_W-1:0];
  end else begin : g_nob
    assign bus.b_out = '0;
    assign tag_b     = '0;
  end

  vh_tag_delay #(.LAT(LAT), .TW(N)) u_tag (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (state == RUN),
    .in_tag  (idx),
    .out_vld (tag_vld),
    .out_tag (tag)
  );

  assign go = start && (state == IDLE || state == DONE);

  always_comb begin
    y32 = '0;
    y32[Y_W-1:0] = bus.y_dut;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (idx == IDX_LAST) state_nxt = (LAT > 0) ? DRAIN : DONE;
      DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      DONE:  if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    busy = (state == RUN) || (state == DRAIN);
    done = (state == DONE);
    pass = done && (mismatch_cnt == 16'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || go) begin
      idx          <= '0;
      drain_cnt    <= '0;
      mismatch_cnt <= '0;
      first_a      <= '0;
      first_b      <= '0;
      first_seen   <= 1'b0;
      signature    <= MISR_SEED;
    end else begin
      // idx parks on the last vector instead of wrapping.
      if (state == RUN && idx != IDX_LAST) idx <= idx + 1'b1;
      if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
      if (tag_vld) begin
        signature <= misr_step(signature, y32);
        if (bus.y_dut != bus.y_ref) begin
          if (mismatch_cnt != 16'hFFFF) mismatch_cnt <= mismatch_cnt + 16'd1;
          if (!first_seen) begin
            first_seen <= 1'b1;
            first_a    <= tag[N-1:B_W];
            first_b    <= tag_b;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vh_sweep_checker.sv
// Directed bench: three checker instances (4+4 LAT=0, 4+4 LAT=3, 8+8 LAT=0)
// driven one after another against hand-built DUT/golden stubs.
module tb_vh_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Signature model: y is the vector value, optionally with bit 0 flipped at
  // the two injected vectors.
  function automatic logic [31:0] misr_model(input logic inj);
    logic [31:0] s;
    logic [31:0] y;
    s = 32'hFFFFFFFF;
    for (int v = 0; v < 256; v++) begin
      y = 32'(v);
      if (inj && (v == 8'h3C || v == 8'h80)) y = y ^ 32'h1;
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ y;
    end
    return s;
  endfunction

  // ---- instance A: 4+4, LAT=0, combinational stub
  logic        st_a, inj;
  logic        busy_a, done_a, pass_a;
  logic [15:0] cnt_a;
  logic [3:0]  fa_a, fb_a;
  logic [31:0] sig_a;
  vh_sweep_checker_if #(.A_W(4), .B_W(4), .Y_W(16)) ifa ();
  assign ifa.y_ref = {8'h0, ifa.a_out, ifa.b_out};
  assign ifa.y_dut = ifa.y_ref ^ {15'h0, inj && ({ifa.a_out, ifa.b_out} == 8'h3C ||
                                                 {ifa.a_out, ifa.b_out} == 8'h80)};
  vh_sweep_checker #(.A_W(4), .B_W(4), .Y_W(16), .LAT(0)) u_a (
    .clk(clk), .rst(rst), .start(st_a), .bus(ifa), .busy(busy_a), .done(done_a),
    .pass(pass_a), .mismatch_cnt(cnt_a), .first_a(fa_a), .first_b(fb_a), .signature(sig_a));

  // ---- instance B: 4+4, LAT=3, registered stubs
  logic        st_b, misal;
  logic        busy_b, done_b, pass_b;
  logic [15:0] cnt_b;
  logic [3:0]  fa_b, fb_b;
  logic [31:0] sig_b;
  logic [7:0]  p1, p2, p3;
  vh_sweep_checker_if #(.A_W(4), .B_W(4), .Y_W(16)) ifb ();
  always @(posedge clk) begin
    p1 <= {ifb.a_out, ifb.b_out};
    p2 <= p1;
    p3 <= p2;
  end
  assign ifb.y_ref = {8'h0, p3};
  assign ifb.y_dut = misal ? {8'h0, p2} : {8'h0, p3};
  vh_sweep_checker #(.A_W(4), .B_W(4), .Y_W(16), .LAT(3)) u_b (
    .clk(clk), .rst(rst), .start(st_b), .bus(ifb), .busy(busy_b), .done(done_b),
    .pass(pass_b), .mismatch_cnt(cnt_b), .first_a(fa_b), .first_b(fb_b), .signature(sig_b));

  // ---- instance C: 8+8, LAT=0, always mismatching
  logic        st_c;
  logic        busy_c, done_c, pass_c;
  logic [15:0] cnt_c;
  logic [7:0]  fa_c, fb_c;
  logic [31:0] sig_c;
  vh_sweep_checker_if #(.A_W(8), .B_W(8), .Y_W(16)) ifc ();
  assign ifc.y_dut = 16'h0;
  assign ifc.y_ref = 16'h1;
  vh_sweep_checker #(.A_W(8), .B_W(8), .Y_W(16), .LAT(0)) u_c (
    .clk(clk), .rst(rst), .start(st_c), .bus(ifc), .busy(busy_c), .done(done_c),
    .pass(pass_c), .mismatch_cnt(cnt_c), .first_a(fa_c), .first_b(fb_c), .signature(sig_c));

  function automatic logic done_of(input int sel);
    case (sel)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: st_a = v;
      1: st_b = v;
      default: st_c = v;
    endcase
  endtask

  // Counts edges until done rises; cyc=1 after the edge that samples start.
  task automatic wait_done(input int sel, input int budget, inout int cyc);
    while (!done_of(sel) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic sweep(input int sel, input int exp_cyc, input string tag);
    int cyc;
    set_start(sel, 1'b1);
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    cyc = 1;
    wait_done(sel, exp_cyc + 20, cyc);
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    int cyc;
    rst = 1'b1; st_a = 1'b0; st_b = 1'b0; st_c = 1'b0; inj = 1'b0; misal = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_pass", 32'(pass_a), 0);
    chk("rst_cnt",  32'(cnt_a), 0);
    chk("rst_sig",  sig_a, 32'hFFFFFFFF);
    chk("rst_ab",   32'({ifa.a_out, ifa.b_out}), 0);
    chk("rst_first", 32'({fa_a, fb_a}), 0);
    rst = 1'b0;

    // clean sweep
    sweep(0, 257, "a_clean");
    chk("a_clean_pass", 32'(pass_a), 1);
    chk("a_clean_cnt",  32'(cnt_a), 0);
    chk("a_clean_sig",  sig_a, misr_model(1'b0));
    repeat (5) @(posedge clk);
    #1;
    chk("a_hold_done", 32'(done_a), 1);
    chk("a_hold_sig",  sig_a, misr_model(1'b0));

    // two injected mismatches
    inj = 1'b1;
    sweep(0, 257, "a_inj");
    chk("a_inj_cnt",  32'(cnt_a), 2);
    chk("a_inj_fa",   32'(fa_a), 32'h3);
    chk("a_inj_fb",   32'(fb_a), 32'hC);
    chk("a_inj_pass", 32'(pass_a), 0);
    chk("a_inj_sig",  sig_a, misr_model(1'b1));

    // start held high: restarts from DONE, ignored while busy
    st_a = 1'b1;
    @(posedge clk); #1;
    chk("a_held_busy", 32'(busy_a), 1);
    chk("a_held_cnt0", 32'(cnt_a), 0);
    chk("a_held_seed", sig_a, 32'hFFFFFFFF);
    cyc = 1;
    wait_done(0, 300, cyc);
    chk("a_held_lat", 32'(cyc), 257);
    chk("a_held_cnt", 32'(cnt_a), 2);
    @(posedge clk); #1;
    chk("a_rerun_busy", 32'(busy_a), 1);
    chk("a_rerun_cnt",  32'(cnt_a), 0);
    chk("a_rerun_seed", sig_a, 32'hFFFFFFFF);
    st_a = 1'b0;
    cyc = 1;
    wait_done(0, 300, cyc);
    chk("a_rerun_lat", 32'(cyc), 257);

    // reset mid-sweep at idx=100
    st_a = 1'b1;
    @(posedge clk); #1;
    st_a = 1'b0;
    cyc = 0;
    while ({ifa.a_out, ifa.b_out} != 8'd100 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("a_mid_idx", 32'({ifa.a_out, ifa.b_out}), 100);
    chk("a_mid_cnt", 32'(cnt_a), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("a_mrst_busy", 32'(busy_a), 0);
    chk("a_mrst_done", 32'(done_a), 0);
    chk("a_mrst_cnt",  32'(cnt_a), 0);
    chk("a_mrst_sig",  sig_a, 32'hFFFFFFFF);
    chk("a_mrst_ab",   32'({ifa.a_out, ifa.b_out}), 0);
    chk("a_mrst_first", 32'({fa_a, fb_a}), 0);
    inj = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("a_idle_busy", 32'(busy_a), 0);
    sweep(0, 257, "a_after_rst");
    chk("a_after_pass", 32'(pass_a), 1);
    chk("a_after_sig",  sig_a, misr_model(1'b0));

    // LAT=3, aligned then misaligned
    sweep(1, 260, "b_aligned");
    chk("b_al_pass", 32'(pass_b), 1);
    chk("b_al_cnt",  32'(cnt_b), 0);
    chk("b_al_sig",  sig_b, misr_model(1'b0));
    misal = 1'b1;
    sweep(1, 260, "b_mis");
    chk("b_mis_cnt",   32'(cnt_b), 255);
    chk("b_mis_first", 32'({fa_b, fb_b}), 0);
    chk("b_mis_pass",  32'(pass_b), 0);

    // 16-bit sweep, every vector mismatching
    sweep(2, 65537, "c_sat");
    chk("c_sat_cnt",   32'(cnt_c), 32'hFFFF);
    chk("c_sat_first", 32'({fa_c, fb_c}), 0);
    chk("c_sat_pass",  32'(pass_c), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
